lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Load/store controller that sits directly upstream of the byte-addressed data/instruction memory in the RV32 core. It accepts one load or store request from the MEM stage, drives the memory's MemRead/MemWrite/addr/data_in/funct3 lines, and returns sign- or zero-extended load data. Misaligned halfword and word accesses are split into sequential byte accesses. The core stalls on `busy` until `rsp_valid`.

Parameters:
ALLOW_MISALIGNED, 1, 1 = split misaligned LH/LHU/LW/SH/SW into byte accesses; 0 = respond with rsp_err and make no memory access.
ADDR_W, 32, address width.

Ports:
clk  in  1  system clock; the memory commits stores on falling edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present from MEM stage
req_ready  out  1  controller idle and accepting
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32 load/store funct3
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle pulse: access complete
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  valid with rsp_valid: illegal funct3 or disallowed misalignment
busy  out  1  stall to core; equals req_valid & ~rsp_valid in IDLE, 1 in any non-IDLE state
mem_read  out  1  to memory MemRead
mem_write  out  1  to memory MemWrite
mem_addr  out  32  to memory addr
mem_wdata  out  32  to memory data_in
mem_funct3  out  3  to memory width select
mem_rdata  in  32  from memory data_out

Behaviour:
- Reset (async): state=IDLE; all mem_* outputs=0; rsp_valid=0; rsp_rdata=0; rsp_err=0; byte counter=0; assembly register=0. Reset mid-access aborts it: mem_read/mem_write drop immediately, and no response is produced.
- req_ready=1 only in IDLE. A request is accepted on the rising edge with req_valid & req_ready. Request fields are latched at acceptance.
- Legal funct3 values:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else goes to DONE with rsp_err=1 and no mem_read/mem_write assertion.
- Alignment rules:
  - Byte accesses are always aligned.
  - Half accesses are aligned when addr[0]=0.
  - Word accesses are aligned when addr[1:0]=00.
- States:
  - IDLE: wait for a request. From IDLE, go to ACCESS if the request is aligned, SPLIT if it is misaligned and ALLOW_MISALIGNED=1, or DONE with err if it is misaligned and ALLOW_MISALIGNED=0.
  - ACCESS: one cycle. mem_addr=addr and mem_funct3=funct3. Drive mem_read or mem_write, with mem_wdata=req_wdata. On the falling edge, mem_rdata is captured into the assembly register. Next state is DONE.
  - SPLIT: N cycles, with N=2 (half) or 4 (word) and byte index k=0..N-1. mem_addr=addr+k.
    - Loads: mem_funct3=100 (LBU). Byte k is captured on the falling edge into assembly bits [8k+7:8k].
    - Stores: mem_funct3=000 (SB) and mem_wdata={24'b0, wdata[8k+7:8k]}.
    - Next state is DONE after k=N-1.
  - DONE: one cycle. rsp_valid=1. rsp_rdata is extended per the original funct3:
    - LB and LH sign-extend from bit 7 and bit 15.
    - LBU and LHU zero-extend.
    - LW passes the word through.
    - Stores and errors return 0.
    - Next state is IDLE.
- Latency from the acceptance edge to rsp_valid high:
  - Aligned access: 2 cycles.
  - Split access: N+1 cycles.
  - Error: 1 cycle.
- mem_read and mem_write are registered. They change only on rising edges (or reset), so they are stable across the falling edge and are never both 1. Outside ACCESS/SPLIT, both are 0 and mem_funct3=010.
- Address arithmetic addr+k wraps modulo 2^ADDR_W. No bounds check is done; the memory owns its range.
- req_valid deassertion while not in IDLE is ignored; the latched request completes.

Test Plan:
1. Memory preloaded with 17 at bytes 383..386. Issue LW 383 (misaligned, ALLOW_MISALIGNED=1) -> 4 mem_read cycles at addresses 383, 384, 385, 386 with mem_funct3=100. Then rsp_valid with rsp_rdata=17, 5 cycles after acceptance.
2. Word 0x00012B49 at 395. Issue LB 395 -> single access, rsp_rdata=73, latency 2. Then issue LH 395 -> 2 byte accesses, rsp_rdata=11081.
3. Issue SW 0xDEADBEEF to 400 (aligned) -> one mem_write with mem_funct3=010. Then LHU 402 -> 0x0000DEAD, LH 402 -> 0xFFFFDEAD, LB 400 -> 0xFFFFFFEF.
4. Issue SH 0xA5C3 to 401 -> SB 0xC3 at 401, then SB 0xA5 at 402. A following LW 400 -> 0x??A5C3?? where bytes 400 and 403 are unchanged (0xDEA5C3EF after test 3).
5. With ALLOW_MISALIGNED=0, issue LW 383 -> rsp_valid and rsp_err=1 one cycle after acceptance, rsp_rdata=0, and mem_read never asserted. Separately, a load with funct3=011 -> rsp_err=1.
6. Assert rst during SPLIT byte k=1 of SW 907 -> mem_write=0 and state IDLE immediately, no rsp_valid, and req_ready=1 after reset release.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// ---------------------------------------------------------------------------
// lsu_ctrl_if
//
// Purpose:
//   Bundles every handshake and bus signal of the load/store controller.
//   There are three groups: the request from the MEM stage, the response and
//   stall back to the core, and the MemRead/MemWrite bus to the byte-addressed
//   data memory.
//
// Signal summary:
//   req_valid   request present from MEM stage
//   req_ready   controller idle and accepting
//   req_we      1 = store, 0 = load
//   req_funct3  RV32 load/store funct3
//   req_addr    byte address (ADDR_W bits)
//   req_wdata   store data, right-aligned
//   rsp_valid   one-cycle pulse: access complete
//   rsp_rdata   extended load data; 0 for stores and errors
//   rsp_err     illegal funct3 or disallowed misalignment (with rsp_valid)
//   busy        stall request to the core
//   mem_read    memory MemRead
//   mem_write   memory MemWrite
//   mem_addr    memory byte address
//   mem_wdata   memory data_in
//   mem_funct3  memory width select
//   mem_rdata   memory data_out
//
// Modports:
//   slave   - the controller side (lsu_ctrl)
//   master  - the core + memory side (whoever drives requests and data_out)
// ---------------------------------------------------------------------------
interface lsu_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              busy;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [2:0]        mem_funct3;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           mem_read, mem_write, mem_addr, mem_wdata, mem_funct3
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           mem_read, mem_write, mem_addr, mem_wdata, mem_funct3
  );

endinterface

// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl
//
// Purpose:
//   Load/store controller sitting directly in front of the byte-addressed
//   data memory of the RV32 core. It takes one load or store from the MEM
//   stage and drives the memory's MemRead/MemWrite/addr/data_in/funct3 lines.
//   It then returns the load data, sign- or zero-extended. Misaligned half
//   and word accesses can be broken into a run of single-byte accesses.
//
// Parameters:
//   ALLOW_MISALIGNED  1 = split misaligned LH/LHU/LW/SH/SW into byte accesses,
//                     0 = answer them with rsp_err and touch no memory
//   ADDR_W            byte address width
//
// Ports:
//   clk   system clock; memory commits stores and this block captures read
//         data on the falling edge
//   rst   asynchronous, active-high reset (aborts any access in flight)
//   bus   lsu_ctrl_if.slave: request, response/stall and memory bus
//
// Latency, counted in rising edges from acceptance to rsp_valid sampled high:
//   aligned access 2, split access N+1 (N = 2 or 4 bytes), error 1.
// ---------------------------------------------------------------------------
module lsu_ctrl #(
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter int ADDR_W           = 32
) (
  input  logic     clk,
  input  logic     rst,
  lsu_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    SPLIT,
    DONE
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        idx_q, idx_d;

  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [2:0]        mem_funct3_q, mem_funct3_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [31:0]       asm_q, asm_d;

  logic              req_legal;
  logic              req_aligned;
  logic [1:0]        last_idx;
  logic [1:0]        next_idx;
  logic [ADDR_W-1:0] next_addr;
  logic [7:0]        next_wbyte;

  // Sign- or zero-extend the assembled load data by the original funct3.
  // An aligned byte/half access already comes back extended from the memory.
  // Re-extending from the low bits here gives the same answer, and it lets
  // the aligned and split paths share one result mux.
  function automatic logic [31:0] extend_load(input logic [2:0] f3,
                                              input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    case (f3)
      F3_LB:   r = {{24{a[7]}}, a[7:0]};
      F3_LH:   r = {{16{a[15]}}, a[15:0]};
      F3_LW:   r = a;
      F3_LBU:  r = {24'b0, a[7:0]};
      F3_LHU:  r = {16'b0, a[15:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Classify the incoming request before it is accepted. Stores only have
  // the three signed widths; loads also have the two unsigned ones. The low
  // two funct3 bits give the access size, and that sets how many address
  // bits must be zero for the access to be aligned.
  always_comb begin
    req_legal = 1'b0;
    case (bus.req_funct3)
      F3_LB, F3_LH, F3_LW: req_legal = 1'b1;
      F3_LBU, F3_LHU:      req_legal = ~bus.req_we;
      default:             req_legal = 1'b0;
    endcase

    req_aligned = 1'b1;
    case (bus.req_funct3[1:0])
      2'b00:   req_aligned = 1'b1;
      2'b01:   req_aligned = ~bus.req_addr[0];
      default: req_aligned = (bus.req_addr[1:0] == 2'b00);
    endcase
  end

  // Byte sequencing for split accesses. The byte counter indexes both the
  // address offset and the store-data byte. Address arithmetic wraps
  // naturally at 2^ADDR_W. A half access ends at byte 1 and a word at byte 3.
  always_comb begin
    last_idx  = (f3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
    next_idx  = idx_q + 2'd1;
    next_addr = addr_q + {{(ADDR_W-2){1'b0}}, next_idx};
    case (next_idx)
      2'd0:    next_wbyte = wdata_q[7:0];
      2'd1:    next_wbyte = wdata_q[15:8];
      2'd2:    next_wbyte = wdata_q[23:16];
      default: next_wbyte = wdata_q[31:24];
    endcase
  end

  // Main next-state logic. Every memory-bus and response output is computed
  // here for the *coming* state and registered below. As a result
  // mem_read/mem_write move only on rising edges and hold steady across the
  // falling edge, where the memory commits stores and read data is captured.
  // Outside ACCESS/SPLIT the bus idles with both strobes low and funct3=LW.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    idx_d        = idx_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    mem_funct3_d = F3_LW;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = '0;
    rsp_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          idx_d   = 2'd0;
          if (!req_legal || (!req_aligned && !ALLOW_MISALIGNED)) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_aligned) begin
            state_d      = ACCESS;
            mem_read_d   = ~bus.req_we;
            mem_write_d  = bus.req_we;
            mem_addr_d   = bus.req_addr;
            mem_funct3_d = bus.req_funct3;
            mem_wdata_d  = bus.req_wdata;
          end else begin
            state_d      = SPLIT;
            mem_read_d   = ~bus.req_we;
            mem_write_d  = bus.req_we;
            mem_addr_d   = bus.req_addr;
            mem_funct3_d = bus.req_we ? F3_LB : F3_LBU;
            mem_wdata_d  = {24'b0, bus.req_wdata[7:0]};
          end
        end
      end

      ACCESS: begin
        state_d     = DONE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = we_q ? 32'b0 : extend_load(f3_q, asm_q);
      end

      SPLIT: begin
        if (idx_q == last_idx) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? 32'b0 : extend_load(f3_q, asm_q);
        end else begin
          idx_d        = next_idx;
          mem_read_d   = ~we_q;
          mem_write_d  = we_q;
          mem_addr_d   = next_addr;
          mem_funct3_d = we_q ? F3_LB : F3_LBU;
          mem_wdata_d  = {24'b0, next_wbyte};
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched request and registered outputs. Reset drops the memory
  // strobes at once, so an access cut off mid-split commits no more bytes
  // and never produces a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      f3_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      idx_q        <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_funct3_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      idx_q        <= idx_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_funct3_q <= mem_funct3_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Assembly register input. An aligned load takes the whole word the memory
  // returns. A split load drops each returned byte (read as LBU) into its
  // lane, so the last byte lands just before the DONE transition.
  always_comb begin
    asm_d = asm_q;
    if (!we_q) begin
      if (state_q == ACCESS) begin
        asm_d = bus.mem_rdata;
      end else if (state_q == SPLIT) begin
        asm_d[{idx_q, 3'b000} +: 8] = bus.mem_rdata[7:0];
      end
    end
  end

  // Read data is captured on the falling edge, midway through each access
  // cycle, while address and strobes are stable.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      asm_q <= '0;
    end else begin
      asm_q <= asm_d;
    end
  end

  // Handshake outputs. Ready is simply "in IDLE". Busy stalls the core as
  // soon as a request shows up and holds it until the controller is idle.
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q == IDLE) ? (bus.req_valid & ~rsp_valid_q) : 1'b1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_funct3 = mem_funct3_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl
//
// Drives two controllers, one with misaligned splitting enabled (A) and one
// with it disabled (B), from a shared request bus. Only the selected one
// sees req_valid. A 4 KiB byte memory serves whichever controller is
// selected. Expected results come from a byte-array reference model that
// applies the load/store rules directly.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqWe = 1'b0;
  logic [2:0]  reqFunct3 = 3'b000;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqWdata = '0;

  int compareCount  = 0;
  int mismatchCount = 0;

  lsu_ctrl_if #(.ADDR_W(32)) ifa ();
  lsu_ctrl_if #(.ADDR_W(32)) ifb ();

  lsu_ctrl #(.ALLOW_MISALIGNED(1'b1), .ADDR_W(32)) dutA (.clk(clk), .rst(rst), .bus(ifa));
  lsu_ctrl #(.ALLOW_MISALIGNED(1'b0), .ADDR_W(32)) dutB (.clk(clk), .rst(rst), .bus(ifb));

  always #5 clk = ~clk;

  // Request fan-out: both controllers see the fields, only one sees valid.
  assign ifa.req_valid  = reqValid & ~sel;
  assign ifb.req_valid  = reqValid & sel;
  assign ifa.req_we     = reqWe;
  assign ifb.req_we     = reqWe;
  assign ifa.req_funct3 = reqFunct3;
  assign ifb.req_funct3 = reqFunct3;
  assign ifa.req_addr   = reqAddr;
  assign ifb.req_addr   = reqAddr;
  assign ifa.req_wdata  = reqWdata;
  assign ifb.req_wdata  = reqWdata;

  logic        obsReady, obsBusy, obsRspValid, obsRspErr, obsMemRead, obsMemWrite;
  logic [31:0] obsRspRdata, obsMemAddr, obsMemWdata;
  logic [2:0]  obsMemFunct3;
  logic [31:0] memRdata;

  assign obsReady     = sel ? ifb.req_ready  : ifa.req_ready;
  assign obsBusy      = sel ? ifb.busy       : ifa.busy;
  assign obsRspValid  = sel ? ifb.rsp_valid  : ifa.rsp_valid;
  assign obsRspErr    = sel ? ifb.rsp_err    : ifa.rsp_err;
  assign obsRspRdata  = sel ? ifb.rsp_rdata  : ifa.rsp_rdata;
  assign obsMemRead   = sel ? ifb.mem_read   : ifa.mem_read;
  assign obsMemWrite  = sel ? ifb.mem_write  : ifa.mem_write;
  assign obsMemAddr   = sel ? ifb.mem_addr   : ifa.mem_addr;
  assign obsMemWdata  = sel ? ifb.mem_wdata  : ifa.mem_wdata;
  assign obsMemFunct3 = sel ? ifb.mem_funct3 : ifa.mem_funct3;
  assign ifa.mem_rdata = memRdata;
  assign ifb.mem_rdata = memRdata;

  // Initial memory contents, including the directed-test preloads.
  function automatic logic [7:0] initByte(input int i);
    case (i)
      383:          return 8'h11;
      384, 385, 386: return 8'h00;
      395:          return 8'h49;
      396:          return 8'h2B;
      397:          return 8'h01;
      398:          return 8'h00;
      default:      return 8'((i * 37 + 11) & 255);
    endcase
  endfunction

  // Byte-addressed memory device: combinational read, store commit on the
  // falling edge. Addresses wrap at 4 KiB.
  logic [7:0]  devMem [0:4095];
  logic [11:0] ma0, ma1, ma2, ma3;
  assign ma0 = obsMemAddr[11:0];
  assign ma1 = ma0 + 12'd1;
  assign ma2 = ma0 + 12'd2;
  assign ma3 = ma0 + 12'd3;

  always_comb begin
    memRdata = '0;
    if (obsMemRead) begin
      case (obsMemFunct3)
        3'b000:  memRdata = {{24{devMem[ma0][7]}}, devMem[ma0]};
        3'b001:  memRdata = {{16{devMem[ma1][7]}}, devMem[ma1], devMem[ma0]};
        3'b010:  memRdata = {devMem[ma3], devMem[ma2], devMem[ma1], devMem[ma0]};
        3'b100:  memRdata = {24'b0, devMem[ma0]};
        3'b101:  memRdata = {16'b0, devMem[ma1], devMem[ma0]};
        default: memRdata = '0;
      endcase
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) devMem[i] = initByte(i);
    forever begin
      @(negedge clk);
      if (obsMemWrite) begin
        case (obsMemFunct3)
          3'b000: devMem[ma0] = obsMemWdata[7:0];
          3'b001: begin
            devMem[ma0] = obsMemWdata[7:0];
            devMem[ma1] = obsMemWdata[15:8];
          end
          3'b010: begin
            devMem[ma0] = obsMemWdata[7:0];
            devMem[ma1] = obsMemWdata[15:8];
            devMem[ma2] = obsMemWdata[23:16];
            devMem[ma3] = obsMemWdata[31:24];
          end
          default: ;
        endcase
      end
    end
  end

  // Reference model memory.
  logic [7:0] refMem [0:4095];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural model of one request: legality, alignment, memory effect,
  // response value, latency and the number of memory accesses.
  task automatic modelRequest(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input bit allow,
                              output logic [31:0] expRdata, output bit expErr,
                              output int expLat, output int expN, output bit expSplit);
    int size;
    bit legal;
    bit misaligned;
    logic [31:0] v;
    size       = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
    legal      = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    misaligned = (addr % size) != 0;
    expRdata   = 0;
    expErr     = 0;
    expSplit   = 0;
    if (!legal || (misaligned && !allow)) begin
      expErr = 1;
      expLat = 1;
      expN   = 0;
      return;
    end
    expSplit = misaligned;
    expN     = misaligned ? size : 1;
    expLat   = misaligned ? size + 1 : 2;
    if (we) begin
      for (int i = 0; i < size; i++) refMem[(addr + i) & 4095] = 8'((wdata >> (8 * i)) & 255);
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) v = v + (32'(refMem[(addr + i) & 4095]) << (8 * i));
      if (f3 == 3'd0 && v >= 128)   v = v - 256;
      if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      expRdata = v;
    end
  endtask

  // Issue one request on the selected controller and follow it to its
  // response. Called at #1 after a rising edge with the controller idle;
  // returns at #1 after a rising edge with the controller idle again.
  task automatic applyStimulus(input bit useB, input bit we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] expRdata;
    bit expErr, expSplit, gotRsp;
    int expLat, expN, k, lat;
    modelRequest(we, f3, addr, wdata, !useB, expRdata, expErr, expLat, expN, expSplit);
    sel = useB;
    reqWe = we;
    reqFunct3 = f3;
    reqAddr = addr;
    reqWdata = wdata;
    reqValid = 1'b1;
    #1;
    checkOutput("readyIdle", obsReady, 1);
    checkOutput("busyOnReq", obsBusy, 1);
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    k = 0;
    lat = 0;
    gotRsp = 0;
    for (int j = 0; j < 12; j++) begin
      checkOutput("busyActive", obsBusy, 1);
      if (obsMemRead || obsMemWrite) begin
        checkOutput("memDir", {30'b0, obsMemRead, obsMemWrite}, we ? 32'd1 : 32'd2);
        checkOutput("memAddr", obsMemAddr, expSplit ? addr + k : addr);
        if (expSplit) begin
          checkOutput("memF3", obsMemFunct3, we ? 3'b000 : 3'b100);
          if (we) checkOutput("memWdata", obsMemWdata, (wdata >> (8 * k)) & 32'hFF);
        end else begin
          checkOutput("memF3", obsMemFunct3, f3);
          if (we) checkOutput("memWdata", obsMemWdata, wdata);
        end
        k++;
      end
      if (obsRspValid) begin
        lat = j + 1;
        gotRsp = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!gotRsp) begin
      checkOutput("rspTimeout", 0, 1);
    end else begin
      checkOutput("latency", lat, expLat);
      checkOutput("accessCount", k, expN);
      checkOutput("rspRdata", obsRspRdata, expRdata);
      checkOutput("rspErr", obsRspErr, expErr);
      @(posedge clk);
      #1;
      checkOutput("rspPulse", obsRspValid, 0);
      checkOutput("readyAfter", obsReady, 1);
    end
  endtask

  initial begin
    logic [31:0] rwData;
    logic [2:0]  legalF3 [0:4];
    bit rWe, rB;
    logic [2:0] rF3;
    logic [31:0] rAddr;

    for (int i = 0; i < 4096; i++) refMem[i] = initByte(i);
    legalF3[0] = 3'b000; legalF3[1] = 3'b001; legalF3[2] = 3'b010;
    legalF3[3] = 3'b100; legalF3[4] = 3'b101;

    // Reset state.
    #3;
    checkOutput("rstReady", obsReady, 1);
    checkOutput("rstRspValid", obsRspValid, 0);
    checkOutput("rstRspRdata", obsRspRdata, 0);
    checkOutput("rstRspErr", obsRspErr, 0);
    checkOutput("rstMemRead", obsMemRead, 0);
    checkOutput("rstMemWrite", obsMemWrite, 0);
    checkOutput("rstMemF3", obsMemFunct3, 0);
    checkOutput("rstMemAddr", obsMemAddr, 0);
    #19;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed sequence.
    applyStimulus(0, 0, 3'b010, 32'd383, 0);
    applyStimulus(0, 0, 3'b000, 32'd395, 0);
    applyStimulus(0, 0, 3'b001, 32'd395, 0);
    applyStimulus(0, 1, 3'b010, 32'd400, 32'hDEADBEEF);
    applyStimulus(0, 0, 3'b101, 32'd402, 0);
    applyStimulus(0, 0, 3'b001, 32'd402, 0);
    applyStimulus(0, 0, 3'b000, 32'd400, 0);
    applyStimulus(0, 1, 3'b001, 32'd401, 32'h0000A5C3);
    applyStimulus(0, 0, 3'b010, 32'd400, 0);
    applyStimulus(1, 0, 3'b010, 32'd383, 0);
    applyStimulus(0, 0, 3'b011, 32'd384, 0);
    applyStimulus(1, 0, 3'b011, 32'd384, 0);
    applyStimulus(0, 0, 3'b010, 32'hFFFFFFFF, 0);
    applyStimulus(0, 1, 3'b100, 32'd500, 32'h12345678);

    // Reset during byte 1 of a split SW 907: only byte 907 was committed.
    sel = 1'b0;
    rwData = 32'h5A6B7C8D;
    refMem[907] = rwData[7:0];
    reqWe = 1'b1;
    reqFunct3 = 3'b010;
    reqAddr = 32'd907;
    reqWdata = rwData;
    reqValid = 1'b1;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    checkOutput("rstSplitK0Addr", obsMemAddr, 907);
    @(posedge clk);
    #1;
    checkOutput("rstSplitK1Addr", obsMemAddr, 908);
    checkOutput("rstSplitK1Write", obsMemWrite, 1);
    rst = 1'b1;
    #1;
    checkOutput("rstAbortWrite", obsMemWrite, 0);
    checkOutput("rstAbortRead", obsMemRead, 0);
    checkOutput("rstAbortIdle", obsReady, 1);
    checkOutput("rstAbortRsp", obsRspValid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      #1;
      checkOutput("rstNoRsp", obsRspValid, 0);
      checkOutput("rstNoWrite", obsMemWrite, 0);
    end
    checkOutput("rstReadyAfter", obsReady, 1);
    applyStimulus(0, 0, 3'b010, 32'd907, 0);

    // Randomized traffic over both controllers.
    for (int n = 0; n < 80; n++) begin
      rB  = ($urandom_range(0, 3) == 0);
      rWe = $urandom_range(0, 1) == 1;
      rF3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : legalF3[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) == 0) rAddr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      else                           rAddr = 32'($urandom_range(0, 4095));
      applyStimulus(rB, rWe, rF3, rAddr, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
